// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pkg
//  Description : Shared constants for the crop controller: register indices,
//                CTRL/STATUS bit positions, FSM state encoding and a helper
//                to pack an (x, y) pair into the register layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package crop_pkg;

    // Register indices on the configuration port
    localparam logic [2:0] c_addr_ctrl      = 3'd0;
    localparam logic [2:0] c_addr_start     = 3'd1;
    localparam logic [2:0] c_addr_end       = 3'd2;
    localparam logic [2:0] c_addr_step      = 3'd3;
    localparam logic [2:0] c_addr_status    = 3'd4;
    localparam logic [2:0] c_addr_act_start = 3'd5;
    localparam logic [2:0] c_addr_act_end   = 3'd6;

    // CTRL bit positions
    localparam int c_ctrl_en     = 0;
    localparam int c_ctrl_pan_en = 1;
    localparam int c_ctrl_commit = 2;

    // STATUS bit positions
    localparam int c_stat_pending = 0;
    localparam int c_stat_err     = 1;

    // Frame-update FSM encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_load  = 2'd2;

    // x lives in the low half-word, y in the high half-word
    function automatic logic [31:0] pack_xy(input logic [15:0] x, input logic [15:0] y);
        return {y, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/crop_pan_axis.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pan_axis
//  Description : One axis of the auto-pan arithmetic. Advances the window by
//                STEP; if the new end would pass the frame edge, the window
//                wraps to the origin keeping its width.
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_pan_axis #(
    parameter int W    = 11,
    parameter int DISP = 1280
) (
    input  logic [W-1:0] cur_start,
    input  logic [W-1:0] cur_end,
    input  logic [W-1:0] step,
    output logic [W-1:0] nxt_start,
    output logic [W-1:0] nxt_end
);

    localparam logic [W:0] c_disp = (W+1)'(DISP);

    logic [W:0] w_sum;

    // One extra bit so an overflowing end is detected rather than wrapped
    always_comb begin
        w_sum = {1'b0, cur_end} + {1'b0, step};
        if (w_sum > c_disp) begin
            nxt_start = '0;
            nxt_end   = cur_end - cur_start;
        end else begin
            nxt_start = cur_start + step;
            nxt_end   = w_sum[W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/crop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crop_ctrl
//  Description : Frame-synchronous crop window controller. Shadow window and
//                pan registers are written through the config port; at each
//                vsync rising edge the FSM validates the shadow values (or
//                computes the auto-pan step) and commits the result to the
//                active window outputs, so the window never moves mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_ctrl
    import crop_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int X_W    = 11,
    parameter int Y_W    = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic           cfg_re,
    input  logic [2:0]     cfg_addr,
    input  logic [31:0]    cfg_wdata,
    output logic [31:0]    cfg_rdata,
    input  logic           vs_in,
    output logic           crop_en,
    output logic [X_W-1:0] start_x,
    output logic [X_W-1:0] end_x,
    output logic [Y_W-1:0] start_y,
    output logic [Y_W-1:0] end_y,
    output logic           frame_irq
);

    localparam logic [X_W:0] c_h_disp = (X_W+1)'(H_DISP);
    localparam logic [Y_W:0] c_v_disp = (Y_W+1)'(V_DISP);

    // Vsync edge detection
    logic           r_vs_q1;
    logic           r_vs_q2;
    logic           r_edge;
    logic           w_edge;

    logic [1:0]     r_state;

    // Software-visible shadow state
    logic           r_en;
    logic           r_pan_en;
    logic [X_W-1:0] r_sh_sx;
    logic [X_W-1:0] r_sh_ex;
    logic [Y_W-1:0] r_sh_sy;
    logic [Y_W-1:0] r_sh_ey;
    logic [X_W-1:0] r_step_x;
    logic [Y_W-1:0] r_step_y;
    logic           r_pending;
    logic           r_pend_defer;
    logic           r_err;
    logic [15:0]    r_frame_cnt;

    // Candidate window captured in CHECK, applied in LOAD
    logic [X_W-1:0] r_cand_sx;
    logic [X_W-1:0] r_cand_ex;
    logic [Y_W-1:0] r_cand_sy;
    logic [Y_W-1:0] r_cand_ey;
    logic           r_cand_load;
    logic           r_cand_bad;

    logic [X_W-1:0] w_cand_sx;
    logic [X_W-1:0] w_cand_ex;
    logic [Y_W-1:0] w_cand_sy;
    logic [Y_W-1:0] w_cand_ey;
    logic           w_cand_load;
    logic           w_cand_bad;
    logic           w_sh_valid;

    logic [X_W-1:0] w_pan_sx;
    logic [X_W-1:0] w_pan_ex;
    logic [Y_W-1:0] w_pan_sy;
    logic [Y_W-1:0] w_pan_ey;

    logic           w_wr_ctrl;
    logic           w_commit_wr;
    logic           w_blocked;
    logic           w_err_clr;
    logic           w_unused_wdata;

    assign w_edge      = r_vs_q1 & ~r_vs_q2;
    assign w_wr_ctrl   = cfg_we && (cfg_addr == c_addr_ctrl);
    assign w_commit_wr = w_wr_ctrl && cfg_wdata[c_ctrl_commit];
    assign w_err_clr   = cfg_we && (cfg_addr == c_addr_status) && cfg_wdata[c_stat_err];
    // A commit landing between the vsync edge and the end of LOAD belongs to the next frame
    assign w_blocked   = w_edge | r_edge | (r_state != c_st_idle);
    assign w_unused_wdata = ^cfg_wdata;

    // Synchronise vsync and register its rising edge as the FSM trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_q1 <= 1'b0;
            r_vs_q2 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_vs_q1 <= vs_in;
            r_vs_q2 <= r_vs_q1;
            r_edge  <= w_edge;
        end
    end

    // Frame update sequencer: IDLE -> CHECK -> LOAD -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (r_edge) r_state <= c_st_check;
                c_st_check: r_state <= c_st_load;
                c_st_load:  r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    // Shadow register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_pan_en <= 1'b0;
            r_sh_sx  <= '0;
            r_sh_sy  <= '0;
            r_sh_ex  <= '0;
            r_sh_ey  <= '0;
            r_step_x <= '0;
            r_step_y <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                c_addr_ctrl: begin
                    r_en     <= cfg_wdata[c_ctrl_en];
                    r_pan_en <= cfg_wdata[c_ctrl_pan_en];
                end
                c_addr_start: begin
                    r_sh_sx <= cfg_wdata[X_W-1:0];
                    r_sh_sy <= cfg_wdata[16+Y_W-1:16];
                end
                c_addr_end: begin
                    r_sh_ex <= cfg_wdata[X_W-1:0];
                    r_sh_ey <= cfg_wdata[16+Y_W-1:16];
                end
                c_addr_step: begin
                    r_step_x <= cfg_wdata[X_W-1:0];
                    r_step_y <= cfg_wdata[16+Y_W-1:16];
                end
                default: ;
            endcase
        end
    end

    // Pending commit bookkeeping and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_pend_defer <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == c_st_load) begin
                r_pending    <= r_pend_defer | w_commit_wr;
                r_pend_defer <= 1'b0;
            end else if (w_commit_wr) begin
                if (w_blocked) r_pend_defer <= 1'b1;
                else           r_pending    <= 1'b1;
            end

            if ((r_state == c_st_load) && r_cand_bad) r_err <= 1'b1;
            else if (w_err_clr)                      r_err <= 1'b0;
        end
    end

    crop_pan_axis #(.W(X_W), .DISP(H_DISP)) u_pan_x (
        .cur_start (start_x),
        .cur_end   (end_x),
        .step      (r_step_x),
        .nxt_start (w_pan_sx),
        .nxt_end   (w_pan_ex)
    );

    crop_pan_axis #(.W(Y_W), .DISP(V_DISP)) u_pan_y (
        .cur_start (start_y),
        .cur_end   (end_y),
        .step      (r_step_y),
        .nxt_start (w_pan_sy),
        .nxt_end   (w_pan_ey)
    );

    // Candidate window: explicit commit wins over auto-pan
    always_comb begin
        w_sh_valid  = (r_sh_sx < r_sh_ex) && (r_sh_sy < r_sh_ey) &&
                      ({1'b0, r_sh_ex} <= c_h_disp) && ({1'b0, r_sh_ey} <= c_v_disp);
        w_cand_sx   = start_x;
        w_cand_ex   = end_x;
        w_cand_sy   = start_y;
        w_cand_ey   = end_y;
        w_cand_load = 1'b0;
        w_cand_bad  = 1'b0;
        if (r_pending) begin
            w_cand_sx   = r_sh_sx;
            w_cand_ex   = r_sh_ex;
            w_cand_sy   = r_sh_sy;
            w_cand_ey   = r_sh_ey;
            w_cand_load = w_sh_valid;
            w_cand_bad  = ~w_sh_valid;
        end else if (r_pan_en) begin
            w_cand_sx   = w_pan_sx;
            w_cand_ex   = w_pan_ex;
            w_cand_sy   = w_pan_sy;
            w_cand_ey   = w_pan_ey;
            w_cand_load = 1'b1;
        end
    end

    // Capture the candidate during CHECK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand_sx   <= '0;
            r_cand_ex   <= '0;
            r_cand_sy   <= '0;
            r_cand_ey   <= '0;
            r_cand_load <= 1'b0;
            r_cand_bad  <= 1'b0;
        end else if (r_state == c_st_check) begin
            r_cand_sx   <= w_cand_sx;
            r_cand_ex   <= w_cand_ex;
            r_cand_sy   <= w_cand_sy;
            r_cand_ey   <= w_cand_ey;
            r_cand_load <= w_cand_load;
            r_cand_bad  <= w_cand_bad;
        end
    end

    // Commit the active window, enable and frame counter at LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            crop_en     <= 1'b0;
            start_x     <= '0;
            start_y     <= '0;
            end_x       <= X_W'(H_DISP);
            end_y       <= Y_W'(V_DISP);
            frame_irq   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (r_state == c_st_load) begin
            if (r_cand_load) begin
                start_x <= r_cand_sx;
                end_x   <= r_cand_ex;
                start_y <= r_cand_sy;
                end_y   <= r_cand_ey;
            end
            crop_en     <= r_en;
            frame_irq   <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
            frame_irq <= 1'b0;
        end
    end

    // Registered read port; data holds until the next read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= '0;
        end else if (cfg_re) begin
            case (cfg_addr)
                c_addr_ctrl:      cfg_rdata <= {30'd0, r_pan_en, r_en};
                c_addr_start:     cfg_rdata <= pack_xy(16'(r_sh_sx), 16'(r_sh_sy));
                c_addr_end:       cfg_rdata <= pack_xy(16'(r_sh_ex), 16'(r_sh_ey));
                c_addr_step:      cfg_rdata <= pack_xy(16'(r_step_x), 16'(r_step_y));
                c_addr_status:    cfg_rdata <= {r_frame_cnt, 14'd0, r_err, r_pending | r_pend_defer};
                c_addr_act_start: cfg_rdata <= pack_xy(16'(start_x), 16'(start_y));
                c_addr_act_end:   cfg_rdata <= pack_xy(16'(end_x), 16'(end_y));
                default:          cfg_rdata <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crop_ctrl
//  Description : Directed self-checking bench for crop_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crop_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic        cfg_re;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        vs_in;
    logic        crop_en;
    logic [10:0] start_x;
    logic [10:0] end_x;
    logic [10:0] start_y;
    logic [10:0] end_y;
    logic        frame_irq;

    int n_checks = 0;
    int n_errors = 0;

    crop_ctrl #(.H_DISP(1280), .V_DISP(720), .X_W(11), .Y_W(11)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .vs_in     (vs_in),
        .crop_en   (crop_en),
        .start_x   (start_x),
        .end_x     (end_x),
        .start_y   (start_y),
        .end_y     (end_y),
        .frame_irq (frame_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        cfg_re   = 1'b1;
        cfg_addr = addr;
        @(negedge clk);
        cfg_re   = 1'b0;
        data     = cfg_rdata;
    endtask

    // One vsync pulse; returns how many frame_irq cycles were seen
    task automatic run_frame(output int irqs);
        irqs = 0;
        @(negedge clk);
        vs_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) vs_in = 1'b0;
            irqs += int'(frame_irq);
        end
    endtask

    logic [31:0] rd;
    int          irqs;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0; vs_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        cfg_read(3'd5, rd); chk("rst_act_start", rd, 32'h0000_0000);
        cfg_read(3'd6, rd); chk("rst_act_end", rd, 32'h02D0_0500);
        chk("rst_crop_en", 32'(crop_en), 32'd0);
        cfg_read(3'd4, rd); chk("rst_status", rd, 32'h0000_0000);

        // Valid commit with detailed latency check
        cfg_write(3'd1, 32'h0032_0064);           // (100,50)
        cfg_write(3'd2, 32'h019A_02E4);           // (740,410)
        cfg_write(3'd0, 32'h0000_0005);           // EN + COMMIT
        cfg_read(3'd4, rd); chk("pending_set", rd, 32'h0000_0001);
        @(negedge clk); vs_in = 1'b1;
        @(negedge clk);                           // posedge k sampled vs_in
        repeat (3) @(negedge clk);                // after k+3
        chk("lat_k3_start_x", 32'(start_x), 32'd0);
        chk("lat_k3_irq", 32'(frame_irq), 32'd0);
        @(negedge clk);                           // after k+4
        chk("lat_k4_start_x", 32'(start_x), 32'd100);
        chk("lat_k4_end_y", 32'(end_y), 32'd410);
        chk("lat_k4_irq", 32'(frame_irq), 32'd1);
        chk("lat_k4_crop_en", 32'(crop_en), 32'd1);
        @(negedge clk); vs_in = 1'b0;
        chk("lat_k5_irq", 32'(frame_irq), 32'd0);
        cfg_read(3'd4, rd); chk("commit_status", rd, 32'h0001_0000);
        cfg_read(3'd6, rd); chk("commit_act_end", rd, 32'h019A_02E4);

        // Invalid commit: end_x beyond frame
        cfg_write(3'd2, 32'h019A_0514);           // (1300,410)
        cfg_write(3'd0, 32'h0000_0005);
        run_frame(irqs); chk("bad_irqs", 32'(irqs), 32'd1);
        cfg_read(3'd6, rd); chk("bad_act_end", rd, 32'h019A_02E4);
        cfg_read(3'd5, rd); chk("bad_act_start", rd, 32'h0032_0064);
        cfg_read(3'd4, rd); chk("bad_status_err", rd, 32'h0002_0002);
        cfg_write(3'd4, 32'h0000_0002);
        cfg_read(3'd4, rd); chk("err_cleared", rd, 32'h0002_0000);

        // Auto-pan with wrap on x, zero step on y
        cfg_write(3'd1, 32'h0032_03E8);           // (1000,50)
        cfg_write(3'd2, 32'h019A_04B0);           // (1200,410)
        cfg_write(3'd0, 32'h0000_0005);
        run_frame(irqs);
        cfg_read(3'd5, rd); chk("pan0_start", rd, 32'h0032_03E8);
        cfg_write(3'd3, 32'h0000_0064);           // step_x = 100
        cfg_write(3'd0, 32'h0000_0003);           // EN + PAN_EN
        run_frame(irqs); chk("pan1_irqs", 32'(irqs), 32'd1);
        cfg_read(3'd5, rd); chk("pan1_start", rd, 32'h0032_0000);
        cfg_read(3'd6, rd); chk("pan1_end", rd, 32'h019A_00C8);
        run_frame(irqs);
        cfg_read(3'd5, rd); chk("pan2_start", rd, 32'h0032_0064);
        cfg_read(3'd6, rd); chk("pan2_end", rd, 32'h019A_012C);

        // COMMIT in the same cycle the edge is seen is deferred one frame
        cfg_write(3'd0, 32'h0000_0001);           // pan off
        cfg_write(3'd1, 32'h003C_00C8);           // (200,60)
        cfg_write(3'd2, 32'h0190_0258);           // (600,400)
        irqs = 0;
        @(negedge clk); vs_in = 1'b1;
        @(negedge clk);                           // posedge k done; edge high now
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0000_0005;
        @(negedge clk);
        cfg_we = 1'b0; cfg_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) vs_in = 1'b0;
            irqs += int'(frame_irq);
        end
        chk("defer_irqs", 32'(irqs), 32'd1);
        cfg_read(3'd5, rd); chk("defer_act_start", rd, 32'h0032_0064);
        cfg_read(3'd4, rd); chk("defer_status", rd, 32'h0006_0001);
        run_frame(irqs);
        cfg_read(3'd5, rd); chk("defer_applied_start", rd, 32'h003C_00C8);
        cfg_read(3'd6, rd); chk("defer_applied_end", rd, 32'h0190_0258);
        cfg_read(3'd4, rd); chk("defer_applied_status", rd, 32'h0007_0000);

        // Reset during CHECK aborts the commit
        cfg_write(3'd1, 32'h0010_0020);
        cfg_write(3'd0, 32'h0000_0005);
        irqs = 0;
        @(negedge clk); vs_in = 1'b1;
        repeat (3) @(negedge clk);                // now in CHECK
        rst = 1'b1; vs_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            irqs += int'(frame_irq);
        end
        chk("rstchk_irqs", 32'(irqs), 32'd0);
        chk("rstchk_crop_en", 32'(crop_en), 32'd0);
        chk("rstchk_start", {5'd0, start_y, 5'd0, start_x}, 32'h0000_0000);
        chk("rstchk_end", {5'd0, end_y, 5'd0, end_x}, 32'h02D0_0500);
        cfg_read(3'd4, rd); chk("rstchk_status", rd, 32'h0000_0000);
        cfg_read(3'd7, rd); chk("reg7_zero", rd, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crop_ctrl.md
# crop_ctrl

Frame-synchronous controller for the video crop stage in the DVP pipeline. Software writes shadow crop-window and pan registers through a simple register port. At each frame start (rising edge of the tapped vertical sync), the block validates the shadow values and commits them to the active window outputs that feed the cropper, so the window never changes mid-frame. An optional auto-pan mode steps the window across the frame by a programmed step per frame, with wrap-around.

## Interface
- H_DISP, 1280, horizontal frame size (pixels)
- V_DISP, 720, vertical frame size (lines)
- X_W, 11, width of x coordinates
- Y_W, 11, width of y coordinates
- clk  in  1  pixel clock; the block's only clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- cfg_we  in  1  register write strobe
- cfg_re  in  1  register read strobe
- cfg_addr  in  3  register index
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, registered
- vs_in  in  1  vertical sync tapped from the cropper input
- crop_en  out  1  cropping enable to the cropper
- start_x / end_x  out  X_W  active window, x; end is exclusive
- start_y / end_y  out  Y_W  active window, y; end is exclusive
- frame_irq  out  1  one-cycle pulse on every commit (LOAD)

## Operation
- Register map:
  - 0 CTRL: [0] EN, [1] PAN_EN, [2] COMMIT (write-1, self-clearing, reads 0)
  - 1 START: x[X_W-1:0], y[16+Y_W-1:16]
  - 2 END: same layout as START
  - 3 PAN_STEP: same layout as START
  - 4 STATUS: [0] pending (RO), [1] err (sticky, write-1-to-clear), [31:16] frame_cnt (RO)
  - 5 ACT_START and 6 ACT_END: read back the active outputs
  - 7: reads 0
- Writing COMMIT=1 sets pending. Shadow registers stay writable while pending; the values present at CHECK are the ones used.
- Frame edge: vs_q1 <= vs_in; vs_q2 <= vs_q1; edge = vs_q1 & ~vs_q2.
- FSM states:
  - IDLE: on edge go to CHECK.
  - CHECK: one cycle. Compute the candidate window and its validity.
  - LOAD: one cycle. Update the outputs, pulse frame_irq, increment frame_cnt (wraps at 16 bits). Return to IDLE.
- Candidate selection in CHECK:
  - If pending: candidate = shadow values. Valid if start_x < end_x, start_y < end_y, end_x <= H_DISP and end_y <= V_DISP.
    - Valid: load the candidate.
    - Invalid: active window unchanged, err = 1.
    - Either way, pending clears in LOAD.
  - Else if PAN_EN: per axis, compute sum = end + step in X_W+1 (or Y_W+1) bits.
    - sum > DISP: start <= 0, end <= end - start (width preserved).
    - Otherwise: start += step, end = sum.
    - Axes are independent. A step of 0 means no motion.
  - Else: window unchanged.
- crop_en <= CTRL.EN at every LOAD, so EN changes take effect at a frame boundary only.
- A COMMIT write in the same cycle as edge, or during CHECK/LOAD, is not applied this frame; pending stays set for the next edge.
- An edge arriving during CHECK/LOAD is ignored.
- A write-1 to err in the same cycle that LOAD sets err: set wins.

## Timing
- Reset values:
  - crop_en = 0; start_x = start_y = 0; end_x = H_DISP; end_y = V_DISP
  - frame_irq = 0; cfg_rdata = 0; frame_cnt = 0
  - all shadow registers 0; pending = 0; err = 0; FSM = IDLE
- Reset mid-operation (including in CHECK/LOAD) aborts the commit and restores these values on the next edge.
- vs_in first sampled high at posedge k:
  - CHECK during cycle k+2
  - LOAD during k+3
  - outputs updated at posedge k+4
  - frame_irq high for cycle k+4
- cfg_rdata is valid the cycle after cfg_re and holds until the next read.
- A register write takes effect at the posedge where cfg_we is sampled.

## Structure
- Package crop_pkg holds:
  - register index constants and CTRL/STATUS bit positions
  - FSM state encoding (IDLE, CHECK, LOAD)
- Sub-module crop_pan_axis (parameter W, DISP): per-axis step/wrap arithmetic, instantiated once for x and once for y.

## Test plan
- Reset, then read ACT regs -> start (0,0), end (1280,720), crop_en=0, STATUS=0.
- Write START=(100,50), END=(740,410), EN=1, COMMIT; pulse vs_in -> outputs change exactly 4 edges after vs sampled, frame_irq one pulse, pending clears, frame_cnt=1.
- Write END=(1300,410) with COMMIT -> after the edge, window unchanged, err=1; write-1 to err -> err=0.
- PAN_EN, window x 1000..1200, step_x=100, two edges -> first x 1100..1300 rejected as out of range, so x becomes 0..200; second edge -> 100..300.
- COMMIT written in the same cycle edge is asserted -> window unchanged this frame, applied on the next vs edge.
- rst asserted during CHECK -> all outputs at reset values and no frame_irq.
